// File: rtl/uart_packet_echo.sv
// UART packet echo: buffers a gap- or size-delimited packet from the serial
// receiver and replays it in-order, reversed, or with a trailing checksum byte.

module uart_pe_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_done,
  output logic [7:0] o_data
);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    r_sync;
  logic          r_busy;
  logic [CW-1:0] r_clk_cnt;
  logic [3:0]    r_bit;
  logic [7:0]    r_shift;

  // Bit 0 is the start bit, timed to its middle; bits 1..8 data, bit 9 stop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync    <= 2'b11;
      r_busy    <= 1'b0;
      r_clk_cnt <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      o_done    <= 1'b0;
      o_data    <= '0;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      o_done <= 1'b0;
      if (!r_busy) begin
        if (!r_sync[1]) begin
          r_busy    <= 1'b1;
          r_clk_cnt <= '0;
          r_bit     <= '0;
        end
      end else if (r_clk_cnt == ((r_bit == 4'd0) ? HALF : FULL)) begin
        r_clk_cnt <= '0;
        if (r_bit == 4'd0) begin
          if (r_sync[1]) r_busy <= 1'b0;
          else           r_bit  <= 4'd1;
        end else if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
          if (r_sync[1]) begin
            o_done <= 1'b1;
            o_data <= r_shift;
          end
        end else begin
          r_shift <= {r_sync[1], r_shift[7:1]};
          r_bit   <= r_bit + 4'd1;
        end
      end else begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end
    end
  end
endmodule

module uart_pe_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic [8:0]    r_shift;
  logic [3:0]    r_bit;
  logic [CW-1:0] r_clk_cnt;

  // Start bit goes out on accept; done pulses with busy dropping after the stop bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tx      <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      r_shift   <= '1;
      r_bit     <= '0;
      r_clk_cnt <= '0;
    end else begin
      o_done <= 1'b0;
      if (!o_busy) begin
        if (i_start) begin
          o_busy    <= 1'b1;
          o_tx      <= 1'b0;
          r_shift   <= {1'b1, i_data};
          r_bit     <= '0;
          r_clk_cnt <= '0;
        end
      end else if (r_clk_cnt == FULL) begin
        r_clk_cnt <= '0;
        if (r_bit == 4'd9) begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
          o_tx   <= 1'b1;
        end else begin
          o_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
          r_bit   <= r_bit + 4'd1;
        end
      end else begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end
    end
  end
endmodule

module uart_packet_echo #(
  parameter int MAX_BYTES  = 32,
  parameter int CLK_FREQ   = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int GAP_CYCLES = 43_400
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic                           iRx,
  output logic                           oTx,
  input  logic [1:0]                     iMode,
  output logic                           oBusy,
  output logic                           oPktDone,
  output logic [$clog2(MAX_BYTES+1)-1:0] oLen,
  output logic                           oOverrun,
  output logic [2:0]                     oState
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int PW = $clog2(MAX_BYTES + 1);
  localparam int IW = $clog2(MAX_BYTES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [PW-1:0] MAXP = PW'(MAX_BYTES);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_LOAD, S_TX, S_WAIT_TX, S_CSUM
  } state_t;

  state_t        r_state;
  logic [7:0]    r_buf [MAX_BYTES];
  logic [PW-1:0] r_wptr, r_rptr, r_rem, r_len;
  logic [GW-1:0] r_gap_cnt;
  logic [7:0]    r_csum, r_tx_byte;
  logic [1:0]    r_mode;
  logic          r_csum_sent, r_tx_start, r_busy, r_pkt_done, r_overrun;

  logic          w_rx_done, w_tx_busy, w_tx_done;
  logic [7:0]    w_rx_data;
  logic [PW-1:0] w_wptr_nxt;
  logic [IW-1:0] w_widx, w_ridx;

  assign w_wptr_nxt = r_wptr + 1'b1;
  assign w_widx     = r_wptr[IW-1:0];
  assign w_ridx     = r_rptr[IW-1:0];

  uart_pe_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk(iClk), .i_rst(iRst), .i_rx(iRx), .o_done(w_rx_done), .o_data(w_rx_data)
  );

  uart_pe_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .i_clk(iClk), .i_rst(iRst), .i_start(r_tx_start), .i_data(r_tx_byte),
    .o_tx(oTx), .o_busy(w_tx_busy), .o_done(w_tx_done)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_rem       <= '0;
      r_len       <= '0;
      r_gap_cnt   <= '0;
      r_csum      <= '0;
      r_tx_byte   <= '0;
      r_mode      <= 2'b00;
      r_csum_sent <= 1'b0;
      r_tx_start  <= 1'b0;
      r_busy      <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_pkt_done <= 1'b0;
      r_overrun  <= 1'b0;
      // Bytes arriving while the packet is being replayed are dropped.
      if (w_rx_done && (r_state inside {S_LOAD, S_TX, S_WAIT_TX, S_CSUM}))
        r_overrun <= 1'b1;
      unique case (r_state)
        S_IDLE: if (w_rx_done) begin
          r_buf[0]  <= w_rx_data;
          r_wptr    <= PW'(1);
          r_csum    <= w_rx_data;
          r_gap_cnt <= '0;
          r_busy    <= 1'b1;
          r_state   <= S_RX;
        end
        S_RX: begin
          if (w_rx_done) begin
            if (r_wptr < MAXP) begin
              r_buf[w_widx] <= w_rx_data;
              r_wptr        <= w_wptr_nxt;
              r_csum        <= r_csum + w_rx_data;
              r_gap_cnt     <= '0;
              if (w_wptr_nxt == MAXP) r_state <= S_LOAD;
            end else begin
              r_overrun <= 1'b1;
            end
          end else if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_LOAD;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          r_mode      <= (iMode == 2'b11) ? 2'b00 : iMode;
          r_len       <= r_wptr;
          r_rptr      <= (iMode == 2'b01) ? r_wptr - 1'b1 : '0;
          r_rem       <= r_wptr;
          r_csum_sent <= 1'b0;
          r_state     <= S_TX;
        end
        S_TX: if (!w_tx_busy) begin
          r_tx_byte  <= r_buf[w_ridx];
          r_tx_start <= 1'b1;
          if (r_mode == 2'b01) begin
            if (r_rem > PW'(1)) r_rptr <= r_rptr - 1'b1;
          end else begin
            r_rptr <= r_rptr + 1'b1;
          end
          r_rem   <= r_rem - 1'b1;
          r_state <= S_WAIT_TX;
        end
        S_WAIT_TX: if (w_tx_done) begin
          if (r_rem != '0) begin
            r_state <= S_TX;
          end else if (r_mode == 2'b10 && !r_csum_sent) begin
            r_state <= S_CSUM;
          end else begin
            r_pkt_done <= 1'b1;
            r_wptr     <= '0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_CSUM: if (!w_tx_busy) begin
          r_tx_byte   <= r_csum;
          r_tx_start  <= 1'b1;
          r_csum_sent <= 1'b1;
          r_state     <= S_WAIT_TX;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oBusy    = r_busy;
  assign oPktDone = r_pkt_done;
  assign oLen     = r_len;
  assign oOverrun = r_overrun;
  assign oState   = r_state;
endmodule

// File: tb/tb_uart_packet_echo.sv
// Bench for uart_packet_echo: serial driver, serial monitor feeding a scoreboard,
// one 32-byte instance for the mode tests and a 4-byte instance for the full-buffer case.

module tb_uart_packet_echo;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int GAP      = 640;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       tx_a, busy_a, done_a, ovr_a;
  logic       tx_b, busy_b, done_b, ovr_b;
  logic [5:0] len_a;
  logic [2:0] len_b;
  logic [2:0] state_a, state_b;

  uart_packet_echo #(.MAX_BYTES(32), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .GAP_CYCLES(GAP)) dut_a (
    .iClk(clk), .iRst(rst), .iRx(rx_a), .oTx(tx_a), .iMode(mode), .oBusy(busy_a),
    .oPktDone(done_a), .oLen(len_a), .oOverrun(ovr_a), .oState(state_a)
  );

  uart_packet_echo #(.MAX_BYTES(4), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .GAP_CYCLES(GAP)) dut_b (
    .iClk(clk), .iRst(rst), .iRx(rx_b), .oTx(tx_b), .iMode(mode), .oBusy(busy_b),
    .oPktDone(done_b), .oLen(len_b), .oOverrun(ovr_b), .oState(state_b)
  );

  int n_checks = 0, n_err = 0;
  int done_a_cnt = 0, done_b_cnt = 0, ovr_a_cnt = 0, ovr_b_cnt = 0;
  int extra_cnt = 0;
  bit mon_ignore = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] pkt_q[$];
  logic [8:0] mon_frame;
  logic [7:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (done_a) done_a_cnt <= done_a_cnt + 1;
    if (done_b) done_b_cnt <= done_b_cnt + 1;
    if (ovr_a)  ovr_a_cnt  <= ovr_a_cnt + 1;
    if (ovr_b)  ovr_b_cnt  <= ovr_b_cnt + 1;
  end

  // Scoreboard side: only one instance transmits at a time and idle is high.
  wire mon_line = tx_a & tx_b;
  always begin
    @(negedge mon_line);
    repeat (BIT / 2) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      repeat (BIT) @(negedge clk);
      mon_frame[i] = mon_line;
    end
    if (!mon_ignore) begin
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("tx_frame", 32'(mon_frame), 32'({1'b1, mon_exp}));
      end else begin
        extra_cnt++;
      end
    end
  end

  // drivers
  task automatic send_byte(input logic [7:0] b, input bit to_b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (to_b) rx_b = f[i];
      else      rx_a = f[i];
      repeat (BIT - 1) @(negedge clk);
    end
  endtask

  task automatic wait_done(input bit on_b, input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ((on_b ? done_b_cnt : done_a_cnt) > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_pkt(input string tag, input logic [1:0] md, input bit on_b, input int max_b);
    int n_eff, base_d, base_o;
    bit ok;
    logic [7:0] sum;
    n_eff = (pkt_q.size() < max_b) ? pkt_q.size() : max_b;
    sum = '0;
    extra_cnt = 0;
    mode = md;
    if (md == 2'b01) begin
      for (int i = n_eff - 1; i >= 0; i--) exp_q.push_back(pkt_q[i]);
    end else begin
      for (int i = 0; i < n_eff; i++) begin
        exp_q.push_back(pkt_q[i]);
        sum = sum + pkt_q[i];
      end
      if (md == 2'b10) exp_q.push_back(sum);
    end
    base_d = on_b ? done_b_cnt : done_a_cnt;
    base_o = on_b ? ovr_b_cnt : ovr_a_cnt;
    foreach (pkt_q[i]) send_byte(pkt_q[i], on_b);
    wait_done(on_b, base_d, ok);
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
    repeat (20) @(negedge clk);
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_extra_bytes"}, 32'(extra_cnt), 32'd0);
    check({tag, "_len"}, on_b ? 32'(len_b) : 32'(len_a), 32'(n_eff));
    check({tag, "_pkt_done_cnt"}, 32'((on_b ? done_b_cnt : done_a_cnt) - base_d), 32'd1);
    check({tag, "_overrun_cnt"}, 32'((on_b ? ovr_b_cnt : ovr_a_cnt) - base_o),
          32'(pkt_q.size() - n_eff));
    check({tag, "_busy_after"}, on_b ? 32'(busy_b) : 32'(busy_a), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit ok;
    int base;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_len", 32'(len_a), 32'd0);
    check("rst_pkt_done", 32'(done_a), 32'd0);
    rst = 1'b0;

    repeat (3000) @(negedge clk);
    check("idle_tx", 32'(tx_a & tx_b), 32'd1);
    check("idle_busy", 32'(busy_a | busy_b), 32'd0);
    check("idle_len", 32'(len_a), 32'd0);
    check("idle_pkt_done_cnt", 32'(done_a_cnt + done_b_cnt), 32'd0);
    check("idle_extra", 32'(extra_cnt), 32'd0);

    pkt_q = '{8'h41, 8'h42, 8'h43};
    run_pkt("echo", 2'b00, 1'b0, 32);
    pkt_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_pkt("reverse", 2'b01, 1'b0, 32);
    pkt_q = '{8'hFF, 8'h02};
    run_pkt("csum", 2'b10, 1'b0, 32);
    pkt_q = '{8'h5A, 8'hC3};
    run_pkt("mode11", 2'b11, 1'b0, 32);
    pkt_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    run_pkt("full4", 2'b00, 1'b1, 4);

    // Reset in the middle of the third transmitted byte.
    mode = 2'b00;
    extra_cnt = 0;
    pkt_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    base = done_a_cnt;
    foreach (pkt_q[i]) send_byte(pkt_q[i], 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    check("rst_first_two", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!tx_a) begin ok = 1'b1; break; end
    end
    check("rst_third_start", 32'(ok), 32'd1);
    mon_ignore = 1'b1;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_tx", 32'(tx_a), 32'd1);
    check("rst_mid_busy", 32'(busy_a), 32'd0);
    check("rst_mid_len", 32'(len_a), 32'd0);
    rst = 1'b0;
    repeat (240) @(negedge clk);
    mon_ignore = 1'b0;
    check("rst_line_idle", 32'(tx_a), 32'd1);
    check("rst_no_pkt_done", 32'(done_a_cnt - base), 32'd0);
    exp_q.delete();
    pkt_q = '{8'h7E};
    run_pkt("after_rst", 2'b00, 1'b0, 32);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end
endmodule
